dat_mem_stk: RTL and testbench
==============================

// Module: dat_mem_stk
// PURPOSE
// Parametrised successor of the 8x256 data memory: single-port RAM with registered reads,
// a self-clearing init sweep after reset, and a hardware stack region (push/pop) at the top
// of the address space. Sits between the datapath (ld/st/push/pop) and the register file;
// `busy` stalls the core until the init sweep completes.
// PARAMETERS
// DW        8   data word width (bits)
// AW        8   address width; depth = 2**AW words
// STK_DEPTH 16  stack capacity in words; occupies addr 2**AW-1 down to 2**AW-STK_DEPTH
// MASK_BASE 60  first address of the constant-mask block (only with DAT_MEM_MASKS_EN)
// PORTS
// clk      in  1                  clock; all state changes on posedge
// reset    in  1                  asynchronous, active-high reset
// dat_in   in  DW                 write/push data
// wr_en    in  1                  random-access write to core[addr]
// rd_en    in  1                  random-access read of core[addr]
// addr     in  AW                 random-access address
// push     in  1                  stack push of dat_in
// pop      in  1                  stack pop to dat_out
// dat_out  out DW                 registered read/pop data
// rd_valid out 1                  one-cycle pulse: dat_out updated this cycle
// busy     out 1                  init sweep in progress; all requests ignored
// sp       out AW                 stack pointer (next free slot, full-descending)
// stk_cnt  out $clog2(STK_DEPTH+1) words on stack
// stk_ovf  out 1                  sticky: push attempted when full
// stk_unf  out 1                  sticky: pop attempted when empty
// BEHAVIOUR
// - Reset (async, any time, aborts any op): state=CLEAR, clr_ptr=0, sp=2**AW-1, stk_cnt=0,
//   dat_out=0, rd_valid=0, busy=1, stk_ovf=0, stk_unf=0. Flags cleared only by reset.
// - CLEAR: each cycle core[clr_ptr]<=init value, clr_ptr++; after writing addr 2**AW-1 go
//   to IDLE. busy is high for exactly 2**AW cycles after reset release. Requests ignored.
// - IDLE, per cycle; stack ops take priority over wr_en/rd_en:
//   push&pop together: ignored; no write, no sp change, no flag, rd_valid=0.
//   push only: if stk_cnt<STK_DEPTH: core[sp]<=dat_in, sp--, stk_cnt++; else no write, stk_ovf<=1.
//   pop only: if stk_cnt>0: dat_out<=core[sp+1], sp++, stk_cnt--, rd_valid<=1 next cycle;
//     else stk_unf<=1, rd_valid=0, dat_out unchanged.
//   no stack op: wr_en -> core[addr]<=dat_in; rd_en -> dat_out<=core[addr], rd_valid=1 next cycle.
//     wr_en&rd_en same addr: read returns OLD data (read-before-write).
//   wr_en/rd_en during a stack op: dropped (the datapath never issues both).
// - Read latency 1 cycle; dat_out holds its last value when rd_valid=0.
// - Random access to the stack region is permitted and unchecked (debug visibility).
// - sp arithmetic is AW-bit; never wraps, since stk_cnt bounds it within the stack region.
// CONFIGURATION
// DAT_MEM_MASKS_EN defined: CLEAR writes constants 0x10,0xE0,0xF0,0xCC,0xAA (DW-bit,
//   zero-extended) to MASK_BASE..MASK_BASE+4; all other addresses are written 0.
// Undefined: CLEAR writes 0 to every address.
// TESTING
// 1 Reset then idle: busy high 256 cycles, then 0; rd_en addr=0x05 -> next cycle rd_valid=1, dat_out=0x00.
// 2 wr_en addr=0x20 dat_in=0xA5, then rd_en addr=0x20 -> dat_out=0xA5 one cycle later; same-cycle
//   wr 0x5A + rd addr=0x20 -> dat_out=0xA5, following read -> 0x5A.
// 3 Push 0x11,0x22,0x33 -> sp=0xFC, stk_cnt=3; three pops -> dat_out 0x33,0x22,0x11, sp=0xFF;
//   4th pop -> stk_unf=1, rd_valid=0.
// 4 17 pushes (STK_DEPTH=16) -> stk_cnt=16, sp=0xEF, stk_ovf=1, core[0xEF] unchanged (0x00).
// 5 push&pop same cycle with stk_cnt=2 -> sp, stk_cnt, dat_out unchanged, no flags.
// 6 DAT_MEM_MASKS_EN: after sweep read addr 60..64 -> 0x10,0xE0,0xF0,0xCC,0xAA; assert reset
//   mid-sweep at cycle 100 -> busy restarts, full 256-cycle sweep, same results.

Source files
------------

// File: rtl/dat_mem_stk.sv
// Single-port data memory with registered reads, post-reset init sweep and a
// descending hardware stack at the top of the address space.
// Optional: define DAT_MEM_MASKS_EN to preload the constant-mask block at MASK_BASE.
module dat_mem_stk #(
    parameter int unsigned DW        = 8,
    parameter int unsigned AW        = 8,
    parameter int unsigned STK_DEPTH = 16,
    parameter int unsigned MASK_BASE = 60
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DW-1:0]                  dat_in,
    input  logic                           wr_en,
    input  logic                           rd_en,
    input  logic [AW-1:0]                  addr,
    input  logic                           push,
    input  logic                           pop,
    output logic [DW-1:0]                  dat_out,
    output logic                           rd_valid,
    output logic                           busy,
    output logic [AW-1:0]                  sp,
    output logic [$clog2(STK_DEPTH+1)-1:0] stk_cnt,
    output logic                           stk_ovf,
    output logic                           stk_unf
);

    localparam int unsigned SW = $clog2(STK_DEPTH + 1);

`ifdef DAT_MEM_MASKS_EN
    localparam logic [7:0] MASK_TBL [5] = '{8'h10, 8'hE0, 8'hF0, 8'hCC, 8'hAA};
`else
    localparam logic [7:0] MASK_TBL [5] = '{default: 8'h00};
`endif

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] clr_ptr, clr_ptr_nxt;
    logic [AW-1:0] sp_nxt;
    logic [SW-1:0] stk_cnt_nxt;
    logic          ovf_nxt, unf_nxt;

    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;
    logic          rd_do;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] mask_off;
    logic [DW-1:0] init_val;

    logic [DW-1:0] core [2**AW];

    // Default build uses an all-zero table, so the sweep clears every word.
    always_comb begin
        mask_off = clr_ptr - AW'(MASK_BASE);
        init_val = '0;
        if (mask_off < AW'(5))
            init_val = DW'(MASK_TBL[mask_off[2:0]]);
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        sp_nxt      = sp;
        stk_cnt_nxt = stk_cnt;
        ovf_nxt     = stk_ovf;
        unf_nxt     = stk_unf;
        mem_we      = 1'b0;
        mem_wa      = addr;
        mem_wd      = dat_in;
        rd_do       = 1'b0;
        rd_addr     = addr;
        case (state)
            CLEAR: begin
                mem_we      = 1'b1;
                mem_wa      = clr_ptr;
                mem_wd      = init_val;
                clr_ptr_nxt = clr_ptr + AW'(1);
                if (clr_ptr == '1)
                    state_nxt = IDLE;
            end
            IDLE: begin
                if (push && !pop) begin
                    if (stk_cnt < SW'(STK_DEPTH)) begin
                        mem_we      = 1'b1;
                        mem_wa      = sp;
                        sp_nxt      = sp - AW'(1);
                        stk_cnt_nxt = stk_cnt + SW'(1);
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                end else if (pop && !push) begin
                    if (stk_cnt != '0) begin
                        rd_do       = 1'b1;
                        rd_addr     = sp + AW'(1);
                        sp_nxt      = sp + AW'(1);
                        stk_cnt_nxt = stk_cnt - SW'(1);
                    end else begin
                        unf_nxt = 1'b1;
                    end
                end else if (!push && !pop) begin
                    mem_we = wr_en;
                    rd_do  = rd_en;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CLEAR;
            clr_ptr  <= '0;
            sp       <= '1;
            stk_cnt  <= '0;
            dat_out  <= '0;
            rd_valid <= 1'b0;
            stk_ovf  <= 1'b0;
            stk_unf  <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_ptr  <= clr_ptr_nxt;
            sp       <= sp_nxt;
            stk_cnt  <= stk_cnt_nxt;
            stk_ovf  <= ovf_nxt;
            stk_unf  <= unf_nxt;
            rd_valid <= rd_do;
            if (rd_do)
                dat_out <= core[rd_addr];
        end
    end

    // Non-blocking write after the registered read gives read-before-write on a shared address.
    always_ff @(posedge clk) begin
        if (mem_we && !reset)
            core[mem_wa] <= mem_wd;
    end

    assign busy = (state == CLEAR);

endmodule

// File: tb/tb_dat_mem_stk.sv
// Self-checking bench for dat_mem_stk: vector table, corner-case sequences and
// randomized traffic against a queue/array reference model.
module tb_dat_mem_stk;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dat_in;
    logic       wr_en, rd_en, push, pop;
    logic [7:0] addr;
    logic [7:0] dat_out;
    logic       rd_valid, busy;
    logic [7:0] sp;
    logic [4:0] stk_cnt;
    logic       stk_ovf, stk_unf;

    int n_chk  = 0;
    int n_fail = 0;

    dat_mem_stk #(.DW(8), .AW(8), .STK_DEPTH(16), .MASK_BASE(60)) dut (
        .clk(clk), .reset(reset), .dat_in(dat_in), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .push(push), .pop(pop), .dat_out(dat_out), .rd_valid(rd_valid),
        .busy(busy), .sp(sp), .stk_cnt(stk_cnt), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       push, pop, wr, rd;
        logic [7:0] addr, din;
        logic [7:0] e_dout;
        logic       e_valid;
        logic [7:0] e_sp;
        int         e_cnt;
        logic       e_ovf, e_unf;
    } vec_t;

    vec_t vecs[$];

    // reference model state
    logic [7:0] m_mem [256];
    logic [7:0] m_q[$];
    logic [7:0] m_dout;
    logic       m_valid, m_ovf, m_unf;

    function automatic logic [7:0] init_at(int a);
`ifdef DAT_MEM_MASKS_EN
        case (a)
            60: return 8'h10;
            61: return 8'hE0;
            62: return 8'hF0;
            63: return 8'hCC;
            64: return 8'hAA;
            default: return 8'h00;
        endcase
`else
        if (a < 0) return 8'hFF;
        return 8'h00;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic p_push, input logic p_pop, input logic p_wr, input logic p_rd,
                       input logic [7:0] p_addr, input logic [7:0] p_din);
        push = p_push; pop = p_pop; wr_en = p_wr; rd_en = p_rd; addr = p_addr; dat_in = p_din;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic p_push, input logic p_pop, input logic p_wr, input logic p_rd,
                       input logic [7:0] p_addr, input logic [7:0] p_din,
                       input logic [7:0] dout, input logic v, input logic [7:0] esp,
                       input int cnt, input logic ovf, input logic unf);
        vec_t t;
        t.push = p_push; t.pop = p_pop; t.wr = p_wr; t.rd = p_rd; t.addr = p_addr; t.din = p_din;
        t.e_dout = dout; t.e_valid = v; t.e_sp = esp; t.e_cnt = cnt; t.e_ovf = ovf; t.e_unf = unf;
        vecs.push_back(t);
    endtask

    task automatic sweep_wait(input string name);
        int n = 0;
        while (busy && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, n, 256);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic model_reset();
        for (int a = 0; a < 256; a++) m_mem[a] = init_at(a);
        m_q.delete();
        m_dout = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic model_step(input logic p_push, input logic p_pop, input logic p_wr,
                              input logic p_rd, input logic [7:0] p_addr, input logic [7:0] p_din);
        m_valid = 1'b0;
        if (p_push && p_pop) begin
        end else if (p_push) begin
            if (m_q.size() < 16) m_q.push_back(p_din);
            else m_ovf = 1'b1;
        end else if (p_pop) begin
            if (m_q.size() > 0) begin
                m_dout = m_q.pop_back();
                m_valid = 1'b1;
            end else m_unf = 1'b1;
        end else begin
            if (p_rd) begin
                m_dout = m_mem[p_addr];
                m_valid = 1'b1;
            end
            if (p_wr) m_mem[p_addr] = p_din;
        end
    endtask

    initial begin
        push = 0; pop = 0; wr_en = 0; rd_en = 0; addr = 0; dat_in = 0;
        reset = 1'b1;
        #1;
        chk("reset_busy", busy, 1);
        chk("reset_sp", sp, 8'hFF);
        chk("reset_cnt", stk_cnt, 0);
        chk("reset_valid", rd_valid, 0);
        chk("reset_dout", dat_out, 0);
        do_reset();

        // 1: sweep length and first read
        sweep_wait("sweep_len");
        chk("busy_after", busy, 0);
        cyc(0, 0, 0, 1, 8'h05, 8'h00);
        chk("rd05_valid", rd_valid, 1);
        chk("rd05_dout", dat_out, 8'h00);

        // 2, 3, 5 and dropped random access during stack op
        add(0,0,1,0,8'h20,8'hA5, 8'h00,0,8'hFF,0,0,0);
        add(0,0,0,1,8'h20,8'h00, 8'hA5,1,8'hFF,0,0,0);
        add(0,0,1,1,8'h20,8'h5A, 8'hA5,1,8'hFF,0,0,0);
        add(0,0,0,1,8'h20,8'h00, 8'h5A,1,8'hFF,0,0,0);
        add(0,0,0,0,8'h00,8'h00, 8'h5A,0,8'hFF,0,0,0);
        add(1,0,0,0,8'h00,8'h11, 8'h5A,0,8'hFE,1,0,0);
        add(1,0,0,0,8'h00,8'h22, 8'h5A,0,8'hFD,2,0,0);
        add(1,0,0,0,8'h00,8'h33, 8'h5A,0,8'hFC,3,0,0);
        add(0,1,0,0,8'h00,8'h00, 8'h33,1,8'hFD,2,0,0);
        add(1,1,0,0,8'h00,8'h77, 8'h33,0,8'hFD,2,0,0);
        add(0,1,0,0,8'h00,8'h00, 8'h22,1,8'hFE,1,0,0);
        add(0,1,0,0,8'h00,8'h00, 8'h11,1,8'hFF,0,0,0);
        add(0,1,0,0,8'h00,8'h00, 8'h11,0,8'hFF,0,0,1);
        add(1,0,1,0,8'h30,8'h44, 8'h11,0,8'hFE,1,0,1);
        add(0,0,0,1,8'h30,8'h00, 8'h00,1,8'hFE,1,0,1);
        add(0,1,0,0,8'h00,8'h00, 8'h44,1,8'hFF,0,0,1);
        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].push, vecs[i].pop, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din);
            chk($sformatf("vec%0d_dout", i), dat_out, vecs[i].e_dout);
            chk($sformatf("vec%0d_valid", i), rd_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_sp", i), sp, vecs[i].e_sp);
            chk($sformatf("vec%0d_cnt", i), stk_cnt, vecs[i].e_cnt);
            chk($sformatf("vec%0d_ovf", i), stk_ovf, vecs[i].e_ovf);
            chk($sformatf("vec%0d_unf", i), stk_unf, vecs[i].e_unf);
        end

        // 4: overflow on the 17th push leaves slot 0xEF untouched
        for (int i = 1; i <= 17; i++) cyc(1, 0, 0, 0, 8'h00, 8'(i));
        chk("full_cnt", stk_cnt, 16);
        chk("full_sp", sp, 8'hEF);
        chk("full_ovf", stk_ovf, 1);
        cyc(0, 0, 0, 1, 8'hEF, 8'h00);
        chk("rdEF_valid", rd_valid, 1);
        chk("rdEF_dout", dat_out, 8'h00);
        cyc(0, 1, 0, 0, 8'h00, 8'h00);
        chk("full_pop", dat_out, 8'h10);
        cyc(0, 0, 0, 0, 8'h00, 8'h00);
        chk("ovf_sticky", stk_ovf, 1);

        // 6: reset mid-sweep restarts a full sweep
        do_reset();
        chk("flags_cleared", {stk_ovf, stk_unf}, 0);
        repeat (100) cyc(0, 0, 0, 0, 8'h00, 8'h00);
        chk("midsweep_busy", busy, 1);
        reset = 1'b1;
        #3;
        chk("async_sp", sp, 8'hFF);
        reset = 1'b0;
        sweep_wait("resweep_len");
        for (int a = 58; a < 67; a++) begin
            cyc(0, 0, 0, 1, 8'(a), 8'h00);
            chk($sformatf("mask%0d", a), dat_out, init_at(a));
        end

        // randomized traffic against the reference model
        do_reset();
        sweep_wait("rand_sweep");
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic p_push, p_pop, p_wr, p_rd;
            logic [7:0] p_addr, p_din;
            int bias;
            bias   = (i < 1000) ? 60 : (i < 2000 ? 25 : 45);
            p_push = ($urandom_range(0, 99) < bias);
            p_pop  = ($urandom_range(0, 99) < 50 - bias / 2);
            p_wr   = ($urandom_range(0, 2) == 0);
            p_rd   = ($urandom_range(0, 2) == 0);
            p_addr = 8'($urandom_range(0, 239));
            p_din  = 8'($urandom);
            cyc(p_push, p_pop, p_wr, p_rd, p_addr, p_din);
            model_step(p_push, p_pop, p_wr, p_rd, p_addr, p_din);
            chk("rand_dout", dat_out, m_dout);
            chk("rand_valid", rd_valid, m_valid);
            chk("rand_sp", sp, 255 - m_q.size());
            chk("rand_cnt", stk_cnt, m_q.size());
            chk("rand_ovf", stk_ovf, m_ovf);
            chk("rand_unf", stk_unf, m_unf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
